// File: rtl/ne_fp_ffp_norm_mwi27_pkg.sv
// Shared constants for the adder-result normalizer.
// Status bit positions, special exponents and mode encodings.
package ne_fp_ffp_norm_mwi27_pkg;

  localparam int ST_NAN  = 2;
  localparam int ST_INF  = 1;
  localparam int ST_ZERO = 0;

  localparam logic [2:0] STAT_NRM  = 3'b000;
  localparam logic [2:0] STAT_NAN  = 3'b100;
  localparam logic [2:0] STAT_INF  = 3'b010;
  localparam logic [2:0] STAT_ZERO = 3'b001;

  localparam logic [9:0] EXP_ZERO = 10'h381;
  localparam logic [9:0] EXP_MAX  = 10'h080;
  localparam int         EXP_MIN  = -126;
  localparam int         EXP_TOP  = 127;

  localparam logic [2:0] MODE_TF32 = 3'b100;
  localparam logic [2:0] MODE_FP8  = 3'b010;
  localparam logic [2:0] MODE_INT8 = 3'b001;

endpackage

// File: rtl/ne_fp_lsc.sv
// Redundant-sign counter: bits below the MSB equal to it,
// counted down to the first differing bit.
module ne_fp_lsc #(
  parameter int MWI = 27
) (
  input  logic [MWI-1:0] m,
  output logic [4:0]     cnt
);

  logic run;

  always_comb begin
    cnt = '0;
    run = 1'b1;
    for (int i = MWI - 2; i >= 0; i--) begin
      if (run && (m[i] == m[MWI-1])) begin
        cnt = cnt + 5'd1;
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ne_fp_ffp_norm_mwi27.sv
// Two-stage normalizer: sign-count/shift, then round,
// exponent range check and special-value encode.
module ne_fp_ffp_norm_mwi27
  import ne_fp_ffp_norm_mwi27_pkg::*;
#(
  parameter int EWI       = 10,
  parameter int MWI       = 27,
  parameter int MWO       = 26,
  parameter int BW_STATUS = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_vld,
  output logic                           in_rdy,
  input  logic [BW_STATUS+EWI+MWI:0]     in_z,
  input  logic [2:0]                     in_mode,
  output logic                           out_vld,
  input  logic                           out_rdy,
  output logic [BW_STATUS+EWI+MWO:0]     out_z,
  output logic [2:0]                     out_mode
);

  localparam int OW = BW_STATUS + 1 + EWI + MWO;

  typedef struct packed {
    logic [BW_STATUS-1:0] st;
    logic                 s;
    logic [EWI:0]         ex;
    logic [MWI-1:0]       sh;
    logic                 mz;
    logic                 byp;
    logic [OW-1:0]        raw;
    logic [2:0]           mode;
  } s1_t;

  logic [MWI-1:0] in_m;
  logic [EWI-1:0] in_e;
  logic [4:0]     cnt;
  s1_t            s1_d, s1_q;
  logic           s1_vld, s2_vld;
  logic           s1_adv, s2_adv;

  assign in_m = in_z[MWI-1:0];
  assign in_e = in_z[MWI+EWI-1:MWI];

  ne_fp_lsc #(.MWI(MWI)) u_lsc (
    .m   (in_m),
    .cnt (cnt)
  );

  always_comb begin
    s1_d      = '0;
    s1_d.st   = in_z[BW_STATUS+EWI+MWI:EWI+MWI+1];
    s1_d.s    = in_z[EWI+MWI];
    s1_d.ex   = {in_e[EWI-1], in_e} - (EWI+1)'(cnt);
    s1_d.sh   = in_m << cnt;
    s1_d.mz   = (in_m == '0);
    s1_d.byp  = |(in_mode & MODE_INT8);
    s1_d.raw  = in_z[OW-1:0];
    s1_d.mode = in_mode;
  end

  logic [MWO-1:0] rm, rnd, mf, msp;
  logic [EWI:0]   ex;
  logic           ovf, lt, gt, n_sp, czero;
  logic           k_nan, k_inf, k_zero, k_ovf;
  logic [OW-1:0]  z_d;

  always_comb begin
    rm    = s1_q.sh[MWI-1:1];
    rnd   = rm + MWO'(s1_q.sh[0] & rm[0]);
    // positive mantissa rounding past its MSB wraps to 0.1000..
    ovf   = ~rm[MWO-1] & rnd[MWO-1];
    mf    = ovf ? {2'b01, {(MWO-2){1'b0}}} : rnd;
    ex    = s1_q.ex + (EWI+1)'(ovf);
    lt    = $signed(ex) < EXP_MIN;
    gt    = $signed(ex) > EXP_TOP;
    msp   = {s1_q.s, s1_q.s, {(MWO-2){1'b0}}};
    n_sp  = ~s1_q.byp & ~s1_q.st[ST_NAN] & ~s1_q.st[ST_INF];
    czero = s1_q.st[ST_ZERO] | s1_q.mz | lt;
    k_nan  = ~s1_q.byp & s1_q.st[ST_NAN];
    k_inf  = ~s1_q.byp & ~s1_q.st[ST_NAN] & s1_q.st[ST_INF];
    k_zero = n_sp & czero;
    k_ovf  = n_sp & ~czero & gt;
    z_d    = {STAT_NRM, mf[MWO-1], ex[EWI-1:0], mf};
    unique case (1'b1)
      s1_q.byp: z_d = s1_q.raw;
      k_nan:    z_d = {STAT_NAN, s1_q.s, EXP_MAX,
                       s1_q.s, s1_q.s, 1'b1, {(MWO-3){1'b0}}};
      k_inf:    z_d = {STAT_INF, s1_q.s, EXP_MAX, msp};
      k_zero:   z_d = {STAT_ZERO, s1_q.s, EXP_ZERO, msp};
      k_ovf:    z_d = {STAT_INF, s1_q.s, EXP_MAX, msp};
      default:  z_d = {STAT_NRM, mf[MWO-1], ex[EWI-1:0], mf};
    endcase
  end

  assign s2_adv  = ~s2_vld | out_rdy;
  assign s1_adv  = ~s1_vld | s2_adv;
  assign in_rdy  = s1_adv;
  assign out_vld = s2_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_q     <= '0;
      s2_vld   <= 1'b0;
      out_z    <= '0;
      out_mode <= '0;
    end else begin
      if (s1_adv) begin
        s1_vld <= in_vld;
        if (in_vld) s1_q <= s1_d;
      end
      if (s2_adv) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          out_z    <= z_d;
          out_mode <= s1_q.mode;
        end
      end
    end
  end

endmodule
